lvds_align_ctrl: RTL

LVDS_ALIGN_CTRL -- requirements
Module: lvds_align_ctrl

---
 rtl/lvds_pkg.sv | 18 +
 rtl/lvds_align_ctrl_if.sv | 33 +++
 rtl/lvds_lane_sel.sv | 26 ++
 rtl/lvds_align_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared types and defaults for the LVDS lane alignment controller.
// Holds the FSM state encoding and the lane-count/training-word defaults.
package lvds_pkg;

  localparam int          LANES_DEF         = 19;
  localparam logic [7:0]  TRAIN_PATTERN_DEF = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CHECK     = 3'd3,
    ST_SLIP      = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/lvds_align_ctrl_if.sv
// Control/status bundle between the alignment controller and its environment.
// master: controller side (takes start/pll_locked/rx_data, drives status and
// bitslip); slave: environment side (drives stimulus, observes status).
interface lvds_align_ctrl_if
  import lvds_pkg::*;
#(
  parameter int LANES = LANES_DEF
);

  logic               start;
  logic               pll_locked;
  logic [LANES*8-1:0] rx_data;
  logic [LANES-1:0]   bitslip;
  logic [LANES-1:0]   lane_locked;
  logic               busy;
  logic               done;
  logic               fail;
  logic               all_locked;
  logic [4:0]         fail_lane;

  modport master (
    input  start, pll_locked, rx_data,
    output bitslip, lane_locked, busy, done,
    output fail, all_locked, fail_lane
  );

  modport slave (
    output start, pll_locked, rx_data,
    input  bitslip, lane_locked, busy, done,
    input  fail, all_locked, fail_lane
  );

endinterface

// File: rtl/lvds_lane_sel.sv
// Lane word mux plus training-pattern compare.
// Ports: rx_data (all lanes), sel (lane index), match (selected word == PATTERN).
module lvds_lane_sel
  import lvds_pkg::*;
#(
  parameter int         LANES   = LANES_DEF,
  parameter int         LW      = 5,
  parameter logic [7:0] PATTERN = TRAIN_PATTERN_DEF
) (
  input  logic [LANES*8-1:0] rx_data,
  input  logic [LW-1:0]      sel,
  output logic               match
);

  logic [7:0] word;

  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel == LW'(i)) word = rx_data[i*8 +: 8];
    end
  end

  assign match = (word == PATTERN);

endmodule

// File: rtl/lvds_align_ctrl.sv
// Per-lane LVDS word alignment: waits for PLL lock, then walks every lane,
// slipping its deserializer until TRAIN_PATTERN is seen MATCH_CYC cycles in a
// row. Ports: rx_slowclk, rst (async, active-high), bus (master modport:
// start, pll_locked, rx_data in; bitslip, lane_locked, busy, done, fail,
// all_locked, fail_lane out).
module lvds_align_ctrl
  import lvds_pkg::*;
#(
  parameter int         LANES         = LANES_DEF,
  parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int         LOCK_CYC      = 1024,
  parameter int         SETTLE_CYC    = 16,
  parameter int         MATCH_CYC     = 64
) (
  input  logic              rx_slowclk,
  input  logic              rst,
  lvds_align_ctrl_if.master bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int KW = $clog2(LOCK_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MATCH_CYC + 1);

  localparam logic [KW-1:0] LOCK_LAST   = KW'(LOCK_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_CYC - 1);
  localparam logic [LW-1:0] LANE_LAST   = LW'(LANES - 1);

  state_t           state;
  logic [KW-1:0]    lock_cnt;
  logic [SW-1:0]    settle_cnt;
  logic [MW-1:0]    match_cnt;
  logic [2:0]       slip_cnt;
  logic [LW-1:0]    lane_idx;
  logic [LANES-1:0] bitslip;
  logic [LANES-1:0] lane_locked;
  logic             fail;
  logic [4:0]       fail_lane;
  logic             match;
  logic [LANES-1:0] lane_bit;
  logic             in_run;

  lvds_lane_sel #(
    .LANES   (LANES),
    .LW      (LW),
    .PATTERN (TRAIN_PATTERN)
  ) u_sel (
    .rx_data (bus.rx_data),
    .sel     (lane_idx),
    .match   (match)
  );

  assign lane_bit = LANES'(1) << lane_idx;

  // Lock loss is only honoured once lane walking has begun.
  assign in_run = (state == ST_SETTLE) || (state == ST_CHECK) ||
                  (state == ST_SLIP)   || (state == ST_NEXT);

  always_ff @(posedge rx_slowclk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      lock_cnt    <= '0;
      settle_cnt  <= '0;
      match_cnt   <= '0;
      slip_cnt    <= '0;
      lane_idx    <= '0;
      bitslip     <= '0;
      lane_locked <= '0;
      fail        <= 1'b0;
      fail_lane   <= '0;
    end else begin
      bitslip <= '0;
      // Lock loss wins over any slip decision, so no pulse escapes.
      if (in_run && !bus.pll_locked) begin
        lane_locked <= '0;
        lock_cnt    <= '0;
        state       <= ST_WAIT_LOCK;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              lane_locked <= '0;
              fail        <= 1'b0;
              fail_lane   <= '0;
              lock_cnt    <= '0;
              state       <= ST_WAIT_LOCK;
            end
          end
          ST_WAIT_LOCK: begin
            if (!bus.pll_locked) begin
              lock_cnt <= '0;
            end else if (lock_cnt == LOCK_LAST) begin
              lane_idx   <= '0;
              slip_cnt   <= '0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              match_cnt <= '0;
              state     <= ST_CHECK;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            if (!match) begin
              state <= ST_SLIP;
            end else if (match_cnt == MATCH_LAST) begin
              lane_locked <= lane_locked | lane_bit;
              state       <= ST_NEXT;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          ST_SLIP: begin
            // slip_cnt==7 means every bit phase has been tried.
            if (slip_cnt != 3'd7) begin
              bitslip    <= lane_bit;
              slip_cnt   <= slip_cnt + 1'b1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else begin
              fail      <= 1'b1;
              fail_lane <= 5'(lane_idx);
              state     <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (lane_idx == LANE_LAST) begin
              state <= ST_DONE;
            end else begin
              lane_idx   <= lane_idx + 1'b1;
              slip_cnt   <= '0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.bitslip     = bitslip;
  assign bus.lane_locked = lane_locked;
  assign bus.fail        = fail;
  assign bus.fail_lane   = fail_lane;
  assign bus.busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done        = (state == ST_DONE);
  assign bus.all_locked  = (state == ST_DONE) && (&lane_locked);

endmodule
